// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding and default sizing for the memory arbiter
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int BLOCK_SIZE_DEF = 4;
    localparam logic [5:0] TIMEOUT_DEF = 6'd63;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant with a last-grant register
module rr_arbiter2 (
    input  logic Clk,
    input  logic Rst,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic gnt_d
);
    logic last_d;
    // on a tie the requester that did not win last time gets the grant
    always_comb gnt_d = (req_i && req_d) ? !last_d : req_d;
    // remember the winner of every grant that is actually taken
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) last_d <= 1'b1;
        else if (take && (req_i || req_d)) last_d <= gnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data memory port between instruction and data caches
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter logic [5:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic I_ReadMiss,
    input  logic [31:0] I_Address,
    output logic I_ReadReady,
    output logic [32*BLOCK_SIZE-1:0] I_Read_data,
    input  logic D_ReadMiss,
    input  logic D_WriteThrough,
    input  logic [31:0] D_Address,
    input  logic [31:0] D_Write_data,
    output logic D_ReadReady,
    output logic D_WriteReady,
    output logic [32*BLOCK_SIZE-1:0] D_Read_data,
    output logic [31:0] M_Address,
    output logic [31:0] M_Write_data,
    output logic M_ReadMiss,
    output logic M_MemWriteThrough,
    input  logic [32*BLOCK_SIZE-1:0] M_Read_data,
    input  logic M_ReadReady,
    input  logic M_WriteReady,
    output logic Busy,
    output logic Timeout
);
    state_t state, state_nx;
    logic owner_d, rd_q, wr_q, gnt_d, hit, any_req, to_q, expire;
    logic [5:0] cnt;
    logic [31:0] addr_q, wdata_q;

    assign any_req = I_ReadMiss || D_ReadMiss || D_WriteThrough;
    assign I_Read_data = M_Read_data;
    assign D_Read_data = M_Read_data;
    assign M_Address = addr_q;
    assign M_Write_data = wdata_q;
    assign Timeout = to_q;

    rr_arbiter2 u_rr (
        .Clk(Clk),
        .Rst(Rst),
        .req_i(I_ReadMiss),
        .req_d(D_ReadMiss || D_WriteThrough),
        .take(state == IDLE),
        .gnt_d(gnt_d)
    );

    // next state, one-cycle memory command in ISSUE, owner-only ready in WAIT
    always_comb begin
        hit = (state == WAIT) && (rd_q ? M_ReadReady : M_WriteReady);
        expire = (state == WAIT) && !hit && (cnt + 6'd1 == TIMEOUT);
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (hit || expire) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        M_ReadMiss = (state == ISSUE) && rd_q;
        M_MemWriteThrough = (state == ISSUE) && wr_q;
        I_ReadReady = hit && !owner_d;
        D_ReadReady = hit && owner_d && rd_q;
        D_WriteReady = hit && owner_d && !rd_q;
        Busy = state != IDLE;
    end

    // state, latched transaction, wait counter and sticky abort flag
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            owner_d <= 1'b0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            cnt <= '0;
            to_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_d <= gnt_d;
                addr_q <= gnt_d ? D_Address : I_Address;
                wdata_q <= gnt_d ? D_Write_data : '0;
                rd_q <= gnt_d ? D_ReadMiss : 1'b1;
                wr_q <= gnt_d && D_WriteThrough;
            end
            cnt <= (state == WAIT) ? cnt + 6'd1 : '0;
            if (expire) to_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-programmable memory model
module tb_mem_arbiter;
    localparam int BS = 4;
    localparam int W = 32*BS;

    logic Clk = 1'b0, Rst = 1'b1;
    logic I_ReadMiss = 1'b0, D_ReadMiss = 1'b0, D_WriteThrough = 1'b0;
    logic [31:0] I_Address = '0, D_Address = '0, D_Write_data = '0;
    logic I_ReadReady, D_ReadReady, D_WriteReady, M_ReadMiss, M_MemWriteThrough, Busy, Timeout;
    logic [W-1:0] I_Read_data, D_Read_data, M_Read_data;
    logic [31:0] M_Address, M_Write_data;
    logic M_ReadReady, M_WriteReady;

    typedef struct {
        logic is_d;
        logic [1:0] cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [W-1:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [2:0] mon_code;
    logic prev_cmd = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int total = 0, bad = 0, cyc = 0, rdy_n = 0, m_cyc = 0, ird_cyc = 0, lat = 3;
    int n0, t_cyc;
    logic suppress = 1'b0, seen;
    logic m_pend, m_rd, m_wr;
    int m_dly;
    logic [31:0] m_a;

    always #5 Clk = ~Clk;

    mem_arbiter #(.BLOCK_SIZE(BS), .TIMEOUT(6'd63)) dut (
        .Clk(Clk), .Rst(Rst),
        .I_ReadMiss(I_ReadMiss), .I_Address(I_Address),
        .I_ReadReady(I_ReadReady), .I_Read_data(I_Read_data),
        .D_ReadMiss(D_ReadMiss), .D_WriteThrough(D_WriteThrough),
        .D_Address(D_Address), .D_Write_data(D_Write_data),
        .D_ReadReady(D_ReadReady), .D_WriteReady(D_WriteReady), .D_Read_data(D_Read_data),
        .M_Address(M_Address), .M_Write_data(M_Write_data),
        .M_ReadMiss(M_ReadMiss), .M_MemWriteThrough(M_MemWriteThrough),
        .M_Read_data(M_Read_data), .M_ReadReady(M_ReadReady), .M_WriteReady(M_WriteReady),
        .Busy(Busy), .Timeout(Timeout)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        if (cmd[0]) ref_mem[a[9:2]] = wd;
        e.is_d = is_d;
        e.cmd = cmd;
        e.addr = a;
        e.wdata = wd;
        e.data = '0;
        if (cmd[1]) for (int i = 0; i < BS; i++) e.data[32*i +: 32] = ref_mem[{a[9:4], 2'(i)}];
        q.push_back(e);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        I_ReadMiss = 1'b0;
        D_ReadMiss = 1'b0;
        D_WriteThrough = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i*4);
        q.delete();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge Clk);
            if (I_ReadReady || D_ReadReady || D_WriteReady) begin
                if (I_ReadReady) I_ReadMiss = 1'b0;
                if (D_ReadReady || D_WriteReady) begin
                    D_ReadMiss = 1'b0;
                    D_WriteThrough = 1'b0;
                end
                return;
            end
        end
        chk("ready_wait_expired", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // memory model: captures a command pulse, answers after lat cycles unless suppressed
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_pend <= 1'b0;
            m_dly <= 0;
            M_ReadReady <= 1'b0;
            M_WriteReady <= 1'b0;
            M_Read_data <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i*4);
        end else begin
            M_ReadReady <= 1'b0;
            M_WriteReady <= 1'b0;
            if (M_ReadMiss || M_MemWriteThrough) begin
                m_pend <= !suppress;
                m_dly <= lat;
                m_rd <= M_ReadMiss;
                m_wr <= M_MemWriteThrough;
                m_a <= M_Address;
                if (M_MemWriteThrough) mem[M_Address[9:2]] <= M_Write_data;
            end else if (m_pend) begin
                if (m_dly == 1) begin
                    m_pend <= 1'b0;
                    M_ReadReady <= m_rd;
                    M_WriteReady <= m_wr;
                    for (int i = 0; i < BS; i++) M_Read_data[32*i +: 32] <= mem[{m_a[9:4], 2'(i)}];
                end else m_dly <= m_dly - 1;
            end
        end
    end

    // monitor: check each issued command and each completion against the scoreboard
    always @(negedge Clk) begin
        mon_code = {I_ReadReady, D_ReadReady, D_WriteReady};
        if (M_ReadMiss || M_MemWriteThrough) begin
            chk("m_pulse_width", prev_cmd, 1'b0);
            m_cyc = cyc;
            if (q.size() == 0) chk("m_unexpected", 1'b1, 1'b0);
            else begin
                chk("m_cmd", {M_ReadMiss, M_MemWriteThrough}, q[0].cmd);
                chk("m_addr", M_Address, q[0].addr);
                if (q[0].cmd[0]) chk("m_wdata", M_Write_data, q[0].wdata);
            end
        end
        prev_cmd = M_ReadMiss || M_MemWriteThrough;
        if (mon_code != 3'b000) begin
            rdy_n++;
            if (I_ReadReady) ird_cyc = cyc;
            if (q.size() == 0) chk("rdy_unexpected", mon_code, 3'b000);
            else begin
                mon_e = q.pop_front();
                chk("rdy_kind", mon_code, !mon_e.is_d ? 3'b100 : mon_e.cmd[1] ? 3'b010 : 3'b001);
                if (mon_e.cmd[1]) chk("rdata", I_ReadReady ? I_Read_data : D_Read_data, mon_e.data);
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_flags", {Busy, Timeout, M_ReadMiss, M_MemWriteThrough, I_ReadReady, D_ReadReady, D_WriteReady}, 7'b0);
        chk("reset_maddr", {M_Address, M_Write_data}, 64'b0);

        push(1'b0, 2'b10, 32'h40, 32'h0);
        I_Address = 32'h40;
        I_ReadMiss = 1'b1;
        wait_done(40);
        idle(4);
        chk("t1_rdy_count", rdy_n, 1);
        chk("t1_sb_empty", q.size(), 0);

        push(1'b1, 2'b01, 32'h10, 32'hDEADBEEF);
        D_Address = 32'h10;
        D_Write_data = 32'hDEADBEEF;
        D_WriteThrough = 1'b1;
        wait_done(40);
        idle(2);
        push(1'b0, 2'b10, 32'h10, 32'h0);
        I_Address = 32'h10;
        I_ReadMiss = 1'b1;
        wait_done(40);
        idle(2);
        chk("t2_sb_empty", q.size(), 0);

        do_reset();
        push(1'b0, 2'b10, 32'h80, 32'h0);
        push(1'b1, 2'b10, 32'h90, 32'h0);
        I_Address = 32'h80;
        D_Address = 32'h90;
        I_ReadMiss = 1'b1;
        D_ReadMiss = 1'b1;
        wait_done(40);
        wait_done(40);
        idle(2);
        chk("t3_ready_to_issue", m_cyc - ird_cyc, 3);
        chk("t3_sb_empty", q.size(), 0);

        push(1'b1, 2'b11, 32'h20, 32'h12345678);
        D_Address = 32'h20;
        D_Write_data = 32'h12345678;
        D_ReadMiss = 1'b1;
        D_WriteThrough = 1'b1;
        wait_done(40);
        idle(4);
        chk("t4_sb_empty", q.size(), 0);

        suppress = 1'b1;
        push(1'b0, 2'b10, 32'h0, 32'h0);
        n0 = rdy_n;
        I_Address = 32'h0;
        I_ReadMiss = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge Clk);
            seen = Timeout;
        end
        t_cyc = cyc;
        chk("t5_timeout_set", Timeout, 1'b1);
        chk("t5_wait_len", t_cyc - m_cyc, 64);
        chk("t5_busy_in_done", Busy, 1'b1);
        I_ReadMiss = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        @(negedge Clk);
        chk("t5_busy_low", Busy, 1'b0);
        idle(5);
        chk("t5_sticky", Timeout, 1'b1);
        chk("t5_no_ready", rdy_n - n0, 0);
        suppress = 1'b0;
        do_reset();
        chk("t5_cleared_by_rst", Timeout, 1'b0);

        lat = 20;
        push(1'b0, 2'b10, 32'h40, 32'h0);
        n0 = rdy_n;
        I_Address = 32'h40;
        I_ReadMiss = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge Clk);
            seen = M_ReadMiss;
        end
        chk("t6_issued", seen, 1'b1);
        idle(5);
        chk("t6_busy_before", Busy, 1'b1);
        Rst = 1'b1;
        #1;
        chk("t6_rst_flags", {Busy, M_ReadMiss, M_MemWriteThrough, I_ReadReady, D_ReadReady, D_WriteReady}, 6'b0);
        chk("t6_rst_maddr", M_Address, 32'h0);
        I_ReadMiss = 1'b0;
        q.delete();
        idle(2);
        Rst = 1'b0;
        idle(30);
        chk("t6_no_ready", rdy_n - n0, 0);
        chk("t6_idle", Busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
